float_to_int_pipe: RTL and testbench

- Pipelined, parametrised float-to-integer converter for the floating point module.
- Generalises the single-cycle 32-bit combinational converter to any IEEE-style format (EXP_W/MAN_W) and any integer width INT_W.
- Adds four per-transaction rounding modes and a valid/ready streaming handshake with back-pressure.
- Sits between the FP register-file read path and the integer writeback path.

---
 rtl/float_to_int_pipe.sv | 100 ++++++++++
 tb/tb_float_to_int_pipe.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/float_to_int_pipe.sv
// float_to_int_pipe: three-stage pipelined float-to-signed-integer converter with rounding modes and valid/ready handshake
// Ports: clk/rst (sync, active-high); in_valid/in_ready/a/rm input stream;
// out_valid/out_ready/d/p_lost/denorm/invalid output stream, all outputs registered in S3.
module float_to_int_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int INT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [1:0]             rm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INT_W-1:0]       d,
  output logic                   p_lost,
  output logic                   denorm,
  output logic                   invalid
);
  localparam int F    = MAN_W + 1;
  localparam int XW   = INT_W + 1 + F;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  logic                 w_en;
  logic [EXP_W-1:0]     w_exp;
  logic [MAN_W-1:0]     w_frac;
  logic                 w_hid;
  logic signed [EW-1:0] w_e;
  logic                 r1_v, r1_sign, r1_den, r1_spec;
  logic [1:0]           r1_rm;
  logic [F-1:0]         r1_sig;
  logic signed [EW-1:0] r1_e;
  logic [EW-1:0]        w_sh;
  logic [XW-1:0]        w_x;
  logic                 w_ovf, w_tiny;
  logic                 r2_v, r2_sign, r2_den, r2_spec, r2_ovf, r2_g, r2_s;
  logic [1:0]           r2_rm;
  logic [INT_W:0]       r2_int;
  logic                 w_inx, w_inc, w_rng_ok, w_bad;
  logic [INT_W:0]       w_mag;
  logic [INT_W-1:0]     w_d;
  assign w_en     = ~out_valid | out_ready;
  assign in_ready = w_en;
  assign w_exp  = a[EXP_W+MAN_W-1:MAN_W];
  assign w_frac = a[MAN_W-1:0];
  assign w_hid  = |w_exp;
  // subnormals share the minimum normal exponent 1 - bias
  assign w_e    = $signed({2'b00, w_hid ? w_exp : EXP_W'(1)}) - EW'(BIAS);
  // fixed point with F fraction bits puts e = -1 at shift 0; e in [-1, INT_W-1] maps to shift [0, INT_W]
  assign w_sh   = r1_e + EW'(1);
  assign w_x    = {{(INT_W+1){1'b0}}, r1_sig} << w_sh;
  assign w_ovf  = int'(r1_e) >= INT_W;
  assign w_tiny = int'(r1_e) < -1;
  assign w_inx  = r2_g | r2_s;
  assign w_inc  = r2_rm == 2'b00 ? r2_g & (r2_s | r2_int[0]) :
                  r2_rm == 2'b01 ? 1'b0 :
                  r2_rm == 2'b10 ? r2_sign & w_inx : ~r2_sign & w_inx;
  // integer part is below 2^INT_W, so the increment cannot wrap INT_W+1 bits
  assign w_mag    = r2_int + {{INT_W{1'b0}}, w_inc};
  assign w_rng_ok = r2_sign ? ~w_mag[INT_W] & (~w_mag[INT_W-1] | ~|w_mag[INT_W-2:0])
                            : ~|w_mag[INT_W:INT_W-1];
  assign w_bad    = r2_spec | r2_ovf | ~w_rng_ok;
  assign w_d      = w_bad ? {1'b1, {(INT_W-1){1'b0}}} :
                    r2_sign ? -w_mag[INT_W-1:0] : w_mag[INT_W-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_v      <= 1'b0;
      r2_v      <= 1'b0;
      out_valid <= 1'b0;
      d         <= '0;
      p_lost    <= 1'b0;
      denorm    <= 1'b0;
      invalid   <= 1'b0;
    end else if (w_en) begin
      r1_v      <= in_valid;
      r1_sign   <= a[EXP_W+MAN_W];
      r1_rm     <= rm;
      r1_sig    <= {w_hid, w_frac};
      r1_e      <= w_e;
      r1_den    <= ~w_hid & |w_frac;
      r1_spec   <= &w_exp;
      r2_v      <= r1_v;
      r2_sign   <= r1_sign;
      r2_rm     <= r1_rm;
      r2_den    <= r1_den;
      r2_spec   <= r1_spec;
      r2_ovf    <= w_ovf;
      r2_int    <= (w_ovf | w_tiny) ? '0 : w_x[XW-1:F];
      r2_g      <= (w_ovf | w_tiny) ? 1'b0 : w_x[F-1];
      r2_s      <= w_tiny ? |r1_sig : w_ovf ? 1'b0 : |w_x[F-2:0];
      out_valid <= r2_v;
      d         <= w_d;
      p_lost    <= ~w_bad & w_inx;
      denorm    <= r2_den;
      invalid   <= w_bad;
    end
  end
endmodule

// File: tb/tb_float_to_int_pipe.sv
// tb_float_to_int_pipe: directed vector table plus streaming and reset sequences for float_to_int_pipe
module tb_float_to_int_pipe;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [31:0] a = 0;
  logic [1:0]  rm = 0;
  logic        in_ready, out_valid, p_lost, denorm, invalid;
  logic [31:0] d;
  logic        in_ready16, out_valid16, p16, dn16, inv16;
  logic [15:0] d16;
  int checks = 0, failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [1:0]  rm;
    logic [31:0] d;
    logic        p, dn, inv, w16;
  } vec_t;
  vec_t tv[$];

  float_to_int_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .rm(rm),
    .out_valid(out_valid), .out_ready(out_ready), .d(d), .p_lost(p_lost),
    .denorm(denorm), .invalid(invalid));

  float_to_int_pipe #(.EXP_W(8), .MAN_W(23), .INT_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .a(a), .rm(rm),
    .out_valid(out_valid16), .out_ready(out_ready), .d(d16), .p_lost(p16),
    .denorm(dn16), .invalid(inv16));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] fa, input logic [1:0] frm, input logic [31:0] fd,
                     input logic fp, input logic fdn, input logic finv, input logic fw16);
    vec_t v;
    v.a = fa; v.rm = frm; v.d = fd; v.p = fp; v.dn = fdn; v.inv = finv; v.w16 = fw16;
    tv.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    @(negedge clk);
    in_valid = 1; a = v.a; rm = v.rm; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd3);
    if (v.w16) begin
      chk({tag, "_d16"}, {16'h0, d16}, v.d);
      chk({tag, "_p16"}, 32'(p16), 32'(v.p));
      chk({tag, "_dn16"}, 32'(dn16), 32'(v.dn));
      chk({tag, "_inv16"}, 32'(inv16), 32'(v.inv));
    end else begin
      chk({tag, "_d"}, d, v.d);
      chk({tag, "_p"}, 32'(p_lost), 32'(v.p));
      chk({tag, "_dn"}, 32'(denorm), 32'(v.dn));
      chk({tag, "_inv"}, 32'(invalid), 32'(v.inv));
    end
  endtask

  logic [31:0] st[8];
  int sent, recv, stall, c_acc, c_out;
  logic hold;
  logic [31:0] hold_d;

  initial begin
    add(32'h3FC00000, 2'd0, 32'd2,          1, 0, 0, 0);
    add(32'h3FC00000, 2'd1, 32'd1,          1, 0, 0, 0);
    add(32'h3FC00000, 2'd2, 32'd1,          1, 0, 0, 0);
    add(32'h3FC00000, 2'd3, 32'd2,          1, 0, 0, 0);
    add(32'h40200000, 2'd0, 32'd2,          1, 0, 0, 0);
    add(32'hBFC00000, 2'd2, 32'hFFFFFFFE,   1, 0, 0, 0);
    add(32'hBFC00000, 2'd1, 32'hFFFFFFFF,   1, 0, 0, 0);
    add(32'hCF000000, 2'd0, 32'h80000000,   0, 0, 0, 0);
    add(32'h4F000000, 2'd0, 32'h80000000,   0, 0, 1, 0);
    add(32'h7F800000, 2'd0, 32'h80000000,   0, 0, 1, 0);
    add(32'h7FC00000, 2'd0, 32'h80000000,   0, 0, 1, 0);
    add(32'h00000001, 2'd3, 32'd1,          1, 1, 0, 0);
    add(32'h00000001, 2'd1, 32'd0,          1, 1, 0, 0);
    add(32'h80000001, 2'd2, 32'hFFFFFFFF,   1, 1, 0, 0);
    add(32'h00000000, 2'd0, 32'd0,          0, 0, 0, 0);
    add(32'h46FFFF00, 2'd0, 32'h00008000,   0, 0, 1, 1);
    add(32'h46FFFF00, 2'd1, 32'h00007FFF,   1, 0, 0, 1);
    add(32'hC0200000, 2'd0, 32'hFFFFFFFE,   1, 0, 0, 0);
    add(32'h3F800000, 2'd0, 32'd1,          0, 0, 0, 0);
    add(32'hFF800000, 2'd1, 32'h80000000,   0, 0, 1, 0);
    add(32'h3F000000, 2'd0, 32'd0,          1, 0, 0, 0);
    add(32'h80000000, 2'd2, 32'd0,          0, 0, 0, 0);
    st = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
           32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    repeat (3) @(negedge clk);
    rst = 0;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_d", d, 32'd0);
    chk("reset_flags", {29'd0, p_lost, denorm, invalid}, 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    foreach (tv[i]) run_vec(tv[i], $sformatf("v%0d", i));

    sent = 0; recv = 0; stall = 0; c_acc = -1; c_out = -1; hold = 0; hold_d = 0;
    for (int c = 0; c < 300 && recv < 8; c++) begin
      @(negedge clk);
      if (stall > 0) begin
        out_ready = 0;
        stall--;
      end else begin
        out_ready = 1;
        if ($urandom_range(0, 2) == 0) stall = $urandom_range(1, 5);
      end
      in_valid = sent < 8;
      a = sent < 8 ? st[sent] : 32'd0;
      rm = 2'd1;
      #1;
      if (hold) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_d", d, hold_d);
      end
      if (out_valid && c_out < 0) c_out = c;
      if (in_valid && in_ready) begin
        if (c_acc < 0) c_acc = c;
        sent++;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("stream_d%0d", recv), d, 32'(recv + 1));
        recv++;
      end
      hold = out_valid && !out_ready;
      hold_d = d;
    end
    chk("stream_count", 32'(recv), 32'd8);
    chk("stream_first_latency", 32'(c_out - c_acc), 32'd3);
    @(negedge clk);
    in_valid = 0; out_ready = 1;
    repeat (4) @(negedge clk);

    in_valid = 1; a = 32'h40400000; rm = 2'd1;
    @(negedge clk);
    a = 32'h40800000;
    @(negedge clk);
    in_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_stale%0d", k), 32'(out_valid), 32'd0);
    end

    run_vec(tv[0], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
